// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int IMEM_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [IMEM_W-1:0] pc;
    logic [31:0]       instr;
  } fe_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fe_entry_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic           flush_i,
  input  entry_t         tail_i,
  output entry_t         head_o,
  output logic [PTR_W:0] count_o,
  output logic           full_o,
  output logic           empty_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the storage is reset too, so the stale head seen while empty is all zeros after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= tail_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem combinationally and queues
// {pc, instr} pairs toward decode; redirects from execute flush the queue.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                IMEM_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [IMEM_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [IMEM_W-1:0] paddr_o,
  input  logic [31:0]       prdata_i,
  input  logic              redirect_valid_i,
  input  logic [IMEM_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic              fe_valid_o,
  input  logic              fe_ready_i,
  output logic [31:0]       fe_instr_o,
  output logic [IMEM_W-1:0] fe_pc_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [IMEM_W-1:0] pc_q, pc_d;
  logic              pop_req, pop, fetch;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  fe_entry_t         fifo_head, fifo_tail;

  assign paddr_o    = pc_q;
  assign fe_valid_o = !fifo_empty;
  assign fe_instr_o = fifo_head.instr;
  assign fe_pc_o    = fifo_head.pc;

  // A head offered during a redirect cycle is killed, so the pop is withheld.
  assign pop_req   = fe_valid_o && fe_ready_i;
  assign pop       = pop_req && !redirect_valid_i;
  assign fetch     = !redirect_valid_i && !halt_i && (!fifo_full || pop_req);
  assign fifo_tail = '{pc: pc_q, instr: prdata_i};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i)
      pc_d = {redirect_pc_i[IMEM_W-1:2], 2'b00};
    else if (fetch)
      pc_d = pc_q + IMEM_W'(INSTR_BYTES);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fe_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fetch),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .tail_i  (fifo_tail),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  count_in_range_a : assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queue scoreboard of expected {pc, instr}.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, redir, halt, ready;
  logic [31:0] rpc, paddr, prdata, fe_instr, fe_pc;
  logic        fe_valid;

  logic        rst2, halt2, ready2;
  logic [31:0] paddr2, prdata2, fe_instr2, fe_pc2;
  logic        fe_valid2;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  assign prdata  = imem(paddr);
  assign prdata2 = imem(paddr2);

  if_fetch_unit #(.IMEM_W(32), .DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .paddr_o(paddr), .prdata_i(prdata),
    .redirect_valid_i(redir), .redirect_pc_i(rpc), .halt_i(halt),
    .fe_valid_o(fe_valid), .fe_ready_i(ready), .fe_instr_o(fe_instr), .fe_pc_o(fe_pc)
  );

  if_fetch_unit #(.IMEM_W(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk_i(clk), .rst_i(rst2), .paddr_o(paddr2), .prdata_i(prdata2),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0), .halt_i(halt2),
    .fe_valid_o(fe_valid2), .fe_ready_i(ready2), .fe_instr_o(fe_instr2), .fe_pc_o(fe_pc2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the scoreboard, advance the model, then cross one edge.
  task automatic step();
    logic pop_m, fetch_m;
    @(negedge clk);
    check("valid", {63'd0, fe_valid}, {63'd0, sb.size() != 0});
    if (sb.size() != 0) check("head", {fe_pc, fe_instr}, sb[0]);
    check("paddr", {32'd0, paddr}, {32'd0, m_pc});
    if (redir) begin
      sb.delete();
      m_pc = rpc & ~32'h3;
    end else begin
      pop_m   = (sb.size() != 0) && ready;
      fetch_m = !halt && ((sb.size() < 2) || pop_m);
      if (pop_m) void'(sb.pop_front());
      if (fetch_m) begin
        sb.push_back({m_pc, imem(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    sb.delete();
    m_pc = 32'h0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; redir = 1'b0; rpc = '0; halt = 1'b0; ready = 1'b1;
    rst2 = 1'b1; halt2 = 1'b0; ready2 = 1'b1;
    #2;
    check("rst_valid", {63'd0, fe_valid}, 64'd0);
    check("rst_paddr", {32'd0, paddr}, 64'd0);
    check("rst_head", {fe_pc, fe_instr}, 64'd0);
    @(posedge clk); #1;
    do_reset();

    // 1: streaming with decode always ready
    step(); check("t1_paddr4", {32'd0, paddr}, 64'h4);
            check("t1_head0", {fe_pc, fe_instr}, {32'h0, 32'hA000_0000});
    step(); check("t1_paddr8", {32'd0, paddr}, 64'h8);
            check("t1_head4", {fe_pc, fe_instr}, {32'h4, 32'hA000_0001});
    step(); check("t1_paddrC", {32'd0, paddr}, 64'hC);
            check("t1_head8", {fe_pc, fe_instr}, {32'h8, 32'hA000_0002});

    // 2: decode stalls from reset, FIFO saturates
    ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("t2_paddr_stall", {32'd0, paddr}, 64'h8);
    check("t2_head_hold", {fe_pc, fe_instr}, {32'h0, 32'hA000_0000});
    check("t2_count_full", {61'd0, dut.u_fifo.count_o}, 64'd2);

    // 4: full FIFO with pop and fetch in the same cycle
    ready = 1'b1;
    step();
    check("t4_count_stays", {61'd0, dut.u_fifo.count_o}, 64'd2);
    check("t4_head_adv", {fe_pc, fe_instr}, {32'h4, 32'hA000_0001});
    step();
    check("t4_tail_pc8", {fe_pc, fe_instr}, {32'h8, 32'hA000_0002});

    // 3: redirect while full
    ready = 1'b0;
    step(); step();
    redir = 1'b1; rpc = 32'h0000_0102;
    step();
    check("t3_valid_off", {63'd0, fe_valid}, 64'd0);
    check("t3_paddr", {32'd0, paddr}, 64'h100);
    redir = 1'b0; ready = 1'b1;
    step();
    check("t3_target", {fe_pc, fe_instr}, {32'h100, 32'hA000_0040});

    // back-to-back redirects with a head killed while decode is ready
    redir = 1'b1; rpc = 32'h0000_0200;
    step();
    rpc = 32'h0000_0303;
    step();
    check("b2b_paddr", {32'd0, paddr}, 64'h300);
    redir = 1'b0;
    step(); step();

    // redirect while halted
    halt = 1'b1; redir = 1'b1; rpc = 32'h0000_0400;
    step();
    redir = 1'b0;
    step(); step();
    check("halt_redir_paddr", {32'd0, paddr}, 64'h400);
    check("halt_redir_valid", {63'd0, fe_valid}, 64'd0);
    halt = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // 6: asynchronous reset mid-burst
    #3 rst = 1'b1;
    #1;
    check("t6_valid_drop", {63'd0, fe_valid}, 64'd0);
    check("t6_paddr_reset", {32'd0, paddr}, 64'h0);
    @(posedge clk); #3;
    rst = 1'b0;
    sb.delete();
    m_pc = 32'h0;
    step(); step();
    check("t6_restart", {fe_pc, fe_instr}, {32'h4, 32'hA000_0001});

    // 5: top-of-address wrap and halt drain on the high-reset instance
    #2 rst2 = 1'b0;
    check("t5_reset_pc", {32'd0, paddr2}, {32'd0, 32'hFFFF_FFFC});
    check("t5_reset_valid", {63'd0, fe_valid2}, 64'd0);
    @(posedge clk); #1;
    check("t5_wrap_paddr", {32'd0, paddr2}, 64'h0);
    check("t5_wrap_head", {fe_pc2, fe_instr2}, {32'hFFFF_FFFC, 32'hDFFF_FFFF});
    halt2 = 1'b1;
    @(posedge clk); #1;
    check("t5_drained", {63'd0, fe_valid2}, 64'd0);
    check("t5_halt_paddr", {32'd0, paddr2}, 64'h0);
    @(posedge clk); #1;
    check("t5_halt_paddr2", {32'd0, paddr2}, 64'h0);
    halt2 = 1'b0;
    @(posedge clk); #1;
    check("t5_resume_paddr", {32'd0, paddr2}, 64'h4);
    check("t5_resume_head", {fe_pc2, fe_instr2}, {32'h0, 32'hA000_0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
